// File: rtl/seq_scan_ctrl_if.sv
// Scan-controller bus: request/word in, serial bit and status out, plus the
// detector's Moore output fed back in.
interface seq_scan_ctrl_if #(
  parameter int N  = 8,
  parameter int CW = 4
);
  logic          start;
  logic [N-1:0]  word;
  logic          generated;
  logic          data;
  logic          det_clr;
  logic          busy;
  logic          done;
  logic [CW-1:0] hit_count;

  modport master (
    output start, word, generated,
    input  data, det_clr, busy, done, hit_count
  );

  modport slave (
    input  start, word, generated,
    output data, det_clr, busy, done, hit_count
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serializes a captured word MSB-first into an external 101 detector and counts its hits.
// Build option: define SEQ_SCAN_ACCUM_EN to let hit_count accumulate across scans.
module seq_scan_ctrl #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst,
  seq_scan_ctrl_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [N-1:0]  word_q;
  logic [IW-1:0] idx;
  logic [CW-1:0] hit_q;
  logic          hit_en;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = CLEAR;
      CLEAR:   state_n = SHIFT;
      SHIFT:   if (idx == '0) state_n = DRAIN;
      DRAIN:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The detector output lags the serial bit by one edge: the first SHIFT edge
  // still sees the cleared detector, and the last bit's hit shows up in DRAIN.
  assign hit_en = bus.generated &&
                  (((state == SHIFT) && (idx != IDX_TOP)) || (state == DRAIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx    <= '0;
      hit_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) word_q <= bus.word;
        end
        CLEAR: begin
          idx <= IDX_TOP;
`ifndef SEQ_SCAN_ACCUM_EN
          hit_q <= '0;
`endif
        end
        SHIFT: begin
          if (idx != '0) idx <= idx - 1'b1;
          if (hit_en)    hit_q <= sat_inc(hit_q);
        end
        DRAIN: begin
          if (hit_en) hit_q <= sat_inc(hit_q);
        end
        default: ;
      endcase
    end
  end

  assign bus.data      = (state == SHIFT) && word_q[idx];
  assign bus.det_clr   = (state == CLEAR);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.hit_count = hit_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed + random bench for seq_scan_ctrl; a second instance with CW=1 exercises saturation.
module tb_seq_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   prev4  = 0;
  int   prev1  = 0;
  bit   accum;

  always #5 clk = ~clk;

  seq_scan_ctrl_if #(.N(8), .CW(4)) bus  ();
  seq_scan_ctrl_if #(.N(8), .CW(1)) bus1 ();

  seq_scan_ctrl #(.N(8), .CW(4)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  seq_scan_ctrl #(.N(8), .CW(1)) u_sat (.clk(clk), .rst(rst), .bus(bus1.slave));

  // External 101 non-overlapping Moore detectors, one per instance.
  logic [1:0] det0, det1;

  function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
    case (s)
      2'd0:    return b ? 2'd1 : 2'd0;
      2'd1:    return b ? 2'd1 : 2'd2;
      2'd2:    return b ? 2'd3 : 2'd0;
      default: return b ? 2'd1 : 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              det0 <= 2'd0;
    else if (bus.det_clr) det0 <= 2'd0;
    else                  det0 <= det_next(det0, bus.data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               det1 <= 2'd0;
    else if (bus1.det_clr) det1 <= 2'd0;
    else                   det1 <= det_next(det1, bus1.data);
  end

  assign bus.generated  = (det0 == 2'd3);
  assign bus1.generated = (det1 == 2'd3);

  // Greedy left-to-right search for non-overlapping "101" in the MSB-first bit string.
  function automatic int ref_hits(input logic [7:0] w);
    int c;
    int i;
    c = 0;
    i = 7;
    while (i >= 2) begin
      if (w[i] && !w[i-1] && w[i-2]) begin
        c++;
        i -= 3;
      end else begin
        i--;
      end
    end
    return c;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] w);
    bus.start  = s;
    bus.word   = w;
    bus1.start = s;
    bus1.word  = w;
  endtask

  // Caller must be between edges with the DUT idle; the next edge accepts start.
  task automatic run_scan(input logic [7:0] w, input bit repulse);
    int k;
    int h;
    int e4;
    int e1;
    logic [7:0] wv;
    wv = w;
    h  = ref_hits(w);
    e4 = accum ? sat(prev4 + h, 15) : sat(h, 15);
    e1 = accum ? sat(prev1 + h, 1)  : sat(h, 1);
    drive(1'b1, w);
    @(posedge clk); #1;
    drive(1'b0, w);
    check("accept_det_clr", bus.det_clr, 1);
    check("accept_busy", bus.busy, 1);
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 4 && repulse) drive(1'b1, ~w);
      if (k == 5 && repulse) drive(1'b0, w);
      if (bus.done) break;
      check("det_clr_low", bus.det_clr, 0);
      check("serial_data", bus.data, (k <= 8) ? wv[8-k] : 1'b0);
    end
    check("done_latency", k, 10);
    check("hit_count", bus.hit_count, e4);
    check("hit_count_sat", bus1.hit_count, e1);
    check("done_data_low", bus.data, 0);
    prev4 = e4;
    prev1 = e1;
    // start raised during DONE must not launch another scan
    drive(1'b1, ~w);
    @(posedge clk); #1;
    drive(1'b0, w);
    check("done_one_cycle", bus.done, 0);
    check("start_in_done_ignored", bus.busy, 0);
    check("hit_held", bus.hit_count, e4);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef SEQ_SCAN_ACCUM_EN
    accum = 1'b1;
`else
    accum = 1'b0;
`endif
    rst = 1'b1;
    drive(1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_data", bus.data, 0);
    check("rst_det_clr", bus.det_clr, 0);
    check("rst_hit", bus.hit_count, 0);
    @(negedge clk);
    rst = 1'b0;

    run_scan(8'b10101010, 1'b0);
    run_scan(8'b10101000, 1'b0);
    run_scan(8'b00000101, 1'b0);
    run_scan(8'hFF,       1'b0);
    run_scan(8'b10101010, 1'b1);

    // Abort mid-SHIFT with an asynchronous reset
    drive(1'b1, 8'b10101010);
    @(posedge clk); #1;
    drive(1'b0, 8'b10101010);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_data", bus.data, 0);
    check("abort_det_clr", bus.det_clr, 0);
    check("abort_done", bus.done, 0);
    check("abort_hit", bus.hit_count, 0);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      check("abort_no_done", bus.done, 0);
    end
    @(negedge clk);
    rst   = 1'b0;
    prev4 = 0;
    prev1 = 0;
    run_scan(8'b10100000, 1'b0);

    run_scan(8'b10101010, 1'b0);
    run_scan(8'b10100000, 1'b0);

    for (int r = 0; r < 12; r++) begin
      run_scan(8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
